req_ack_responder: RTL and testbench
====================================

# req_ack_responder

Responder side of the fixed-latency req/ack handshake. It detects each rising edge of `req` and answers with an `ack` pulse a programmed number of clock edges later, so that with `cfg_delay = 2` the property "rose(req) |=> ##2 rose(ack)" holds. Only one request is serviced at a time; requests that rise while one is in service are dropped and counted. It sits opposite any initiator that drives `req` synchronously to `clk`.

## Interface
Parameters:
- `DLY_W`, 4: width of `cfg_delay`.
- `ACK_WIDTH`, 1: number of cycles `ack` is held high (≥1).
- `CNT_W`, 8: width of the statistics counters.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request from initiator, synchronous to `clk`.
- `cfg_delay`  in  DLY_W  request-to-ack delay in cycles; 0 is treated as 1.
- `ack`  out  1  registered acknowledge pulse.
- `busy`  out  1  high while state ≠ IDLE.
- `drop_err`  out  1  sticky; set on the first dropped request.
- `served_cnt`  out  CNT_W  accepted requests, saturating.
- `drop_cnt`  out  CNT_W  dropped requests, saturating.

## Operation
- Rise detect: `req_q` is a register of `req`. `rise = req & ~req_q`. `req_q` resets to 0, so `req` high at the first edge after reset counts as a rise.
- FSM states are IDLE, WAIT and ACK.
  - IDLE with `rise`: load `dcnt = max(cfg_delay,1) - 1`, go to WAIT, increment `served_cnt`.
  - WAIT: if `dcnt == 0`, go to ACK, set `ack = 1` and `wcnt = ACK_WIDTH - 1`. Otherwise decrement `dcnt`.
  - ACK: if `wcnt == 0`, go to IDLE and set `ack = 0`. Otherwise decrement `wcnt`.
- `cfg_delay` is sampled only on the IDLE→WAIT edge. Changes during WAIT or ACK have no effect on the current request.
- A `rise` in WAIT or ACK (including the last ACK cycle) is dropped: increment `drop_cnt` and set `drop_err`. The request in service is unaffected.
- A rise is accepted only when it is sampled in IDLE. A rise on the same edge as ACK→IDLE is therefore dropped.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- `drop_err` is cleared only by reset.
- `ack` is driven directly from a flop, with no combinational path from `req`.

## Timing
- Reset values: `ack` = 0, `busy` = 0, `drop_err` = 0, both counters = 0, state = IDLE, `req_q` = 0.
- Latency: a rise sampled at edge t makes `ack` go high just after edge t+D, where D = max(`cfg_delay`,1). `ack` is therefore first sampled high at edge t+D+1.
  - D = 2 gives `ack` sampled at t+3, which matches "|=> ##2".
- `ack` stays high for exactly ACK_WIDTH sampled edges.
- `busy` rises just after edge t and falls just after the edge that clears `ack`.
- Minimum spacing between two accepted rises is D+ACK_WIDTH+1 edges.
- `req` level after the rise is ignored; `req` may drop before `ack` arrives.
- Reset asserted mid-WAIT or mid-ACK: `ack` drops immediately (asynchronously) and all state returns to reset values. No ack is issued for the aborted request after reset releases.

## Structure
- Package `req_ack_pkg` holds:
  - the `state_t` enum (IDLE, WAIT, ACK);
  - the default delay constant `REQ_ACK_DLY = 2`, shared with initiator-side benches and assertions.
- Sub-module `rise_detect`: one flop plus an AND gate, async active-low reset, output `rise`. It is reusable for `ack` monitoring on the initiator side.
- Everything else (FSM, `dcnt`/`wcnt`, counters) is in one always_ff block plus next-state logic.

## Test plan
- `cfg_delay` = 2, ACK_WIDTH = 1, single 5 ns `req` pulse rising mid-cycle:
  - `ack` is first sampled high 3 edges after the rise edge, for one cycle;
  - `served_cnt` = 1;
  - the bound "rose(req) |=> ##2 rose(ack)" assertion passes.
- `cfg_delay` = 0 and `cfg_delay` = 15: `ack` is sampled at t+2 and t+16 respectively.
- Second rise 2 edges after the first (`cfg_delay` = 2):
  - one `ack` only;
  - `drop_cnt` = 1 and `drop_err` = 1;
  - a third rise after `busy` falls is served normally.
- ACK_WIDTH = 3, and `cfg_delay` changed from 2 to 5 during WAIT:
  - `ack` is high for exactly 3 cycles starting at t+3;
  - the next request uses delay 5.
- `rst_n` asserted for one cycle during WAIT: `ack` never rises for that request and all outputs read 0. Separately, `req` held high through reset release yields one ack at t+3.
- 300 requests spaced 6 cycles apart with CNT_W = 8: `served_cnt` saturates at 255, and `ack` timing is unchanged.

Source files
------------

// File: rtl/req_ack_responder_pkg.sv
// rtl/req_ack_responder_pkg.sv - shared types and constants for the req/ack handshake
// Default delay is shared with initiator-side benches and checkers.
package req_ack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int REQ_ACK_DLY = 2;

endpackage

// File: rtl/req_ack_responder_if.sv
// rtl/req_ack_responder_if.sv - req/ack handshake bundle
// The initiator drives req and the responder drives ack.
interface req_ack_responder_if;

    logic req;
    logic ack;

    modport master (output req, input ack);
    modport slave  (input req, output ack);

endinterface

// File: rtl/req_ack_responder_rise_detect.sv
// rtl/req_ack_responder_rise_detect.sv - single-flop rising-edge detector
// The delay flop resets to 0, so a level already high after reset reads as a rise.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/req_ack_responder.sv
// rtl/req_ack_responder.sv - fixed-latency responder answering each req rise with an ack pulse
// One request in service at a time; rises seen outside IDLE are dropped and counted.
module req_ack_responder
    import req_ack_pkg::*;
#(
    parameter int DLY_W     = 4,
    parameter int ACK_WIDTH = 1,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    req_ack_responder_if.slave   bus,
    input  logic [DLY_W-1:0]     cfg_delay,
    output logic                 busy,
    output logic                 drop_err,
    output logic [CNT_W-1:0]     served_cnt,
    output logic [CNT_W-1:0]     drop_cnt
);

    localparam int WCNT_W = (ACK_WIDTH > 1) ? $clog2(ACK_WIDTH) : 1;

    state_t            state;
    state_t            state_n;
    logic [DLY_W-1:0]  dcnt;
    logic [DLY_W-1:0]  dcnt_n;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_n;
    logic              ack_q;
    logic              ack_n;
    logic              accept;
    logic              drop;
    logic              rise;

    rise_detect u_rise_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (bus.req),
        .rise  (rise)
    );

    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        wcnt_n  = wcnt;
        ack_n   = ack_q;
        accept  = 1'b0;
        drop    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    accept  = 1'b1;
                    state_n = WAIT;
                    // A programmed delay of 0 behaves as 1
                    dcnt_n  = (cfg_delay == '0) ? '0 : cfg_delay - DLY_W'(1);
                end
            end
            WAIT: begin
                drop = rise;
                if (dcnt == '0) begin
                    state_n = ACK;
                    ack_n   = 1'b1;
                    wcnt_n  = WCNT_W'(ACK_WIDTH - 1);
                end else begin
                    dcnt_n = dcnt - DLY_W'(1);
                end
            end
            ACK: begin
                drop = rise;
                if (wcnt == '0) begin
                    state_n = IDLE;
                    ack_n   = 1'b0;
                end else begin
                    wcnt_n = wcnt - WCNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                ack_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dcnt       <= '0;
            wcnt       <= '0;
            ack_q      <= 1'b0;
            drop_err   <= 1'b0;
            served_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            state <= state_n;
            dcnt  <= dcnt_n;
            wcnt  <= wcnt_n;
            ack_q <= ack_n;
            if (accept && (served_cnt != '1)) begin
                served_cnt <= served_cnt + CNT_W'(1);
            end
            if (drop) begin
                drop_err <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.ack = ack_q;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_req_ack_responder.sv
// tb/tb_req_ack_responder.sv - directed self-checking bench for req_ack_responder
module tb_req_ack_responder;
    import req_ack_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cfg1;
    logic [3:0] cfg3;
    logic       busy1, busy3;
    logic       derr1, derr3;
    logic [7:0] srv1, srv3;
    logic [7:0] dcnt1, dcnt3;
    int         checks = 0;
    int         errors = 0;

    req_ack_responder_if bus1 ();
    req_ack_responder_if bus3 ();

    req_ack_responder #(.DLY_W(4), .ACK_WIDTH(1), .CNT_W(8)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus1),
        .cfg_delay  (cfg1),
        .busy       (busy1),
        .drop_err   (derr1),
        .served_cnt (srv1),
        .drop_cnt   (dcnt1)
    );

    req_ack_responder #(.DLY_W(4), .ACK_WIDTH(3), .CNT_W(8)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus3),
        .cfg_delay  (cfg3),
        .busy       (busy3),
        .drop_err   (derr3),
        .served_cnt (srv3),
        .drop_cnt   (dcnt3)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit w3, input logic v);
        if (w3) bus3.req = v;
        else    bus1.req = v;
    endtask

    // 5 ns pulse straddling the next rising edge (edge t)
    task automatic rise_pulse(input bit w3);
        @(negedge clk);
        #2;
        set_req(w3, 1'b1);
        #5;
        set_req(w3, 1'b0);
    endtask

    // k-th negedge after edge t: ack high for k in [d, d+w), busy for k < d+w
    task automatic expect_ack(input bit w3, input int d, input int w, input string tag);
        for (int k = 0; k <= d + w + 1; k++) begin
            @(negedge clk);
            chk(w3 ? bus3.ack : bus1.ack, 32'((k >= d) && (k < d + w)), {tag, " ack"});
            chk(w3 ? busy3 : busy1, 32'(k < d + w), {tag, " busy"});
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        bus1.req = 1'b0;
        bus3.req = 1'b0;
        cfg1     = 4'(REQ_ACK_DLY);
        cfg3     = 4'(REQ_ACK_DLY);
        repeat (3) @(negedge clk);
        chk(bus1.ack, 0, "reset ack1");
        chk(busy1, 0, "reset busy1");
        chk(derr1, 0, "reset drop_err1");
        chk(srv1, 0, "reset served1");
        chk(dcnt1, 0, "reset drop_cnt1");
        chk(bus3.ack, 0, "reset ack3");
        chk(busy3, 0, "reset busy3");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        rise_pulse(0);
        expect_ack(0, 2, 1, "d2");
        chk(srv1, 1, "d2 served");
        chk(dcnt1, 0, "d2 drop_cnt");

        cfg1 = 4'd0;
        rise_pulse(0);
        expect_ack(0, 1, 1, "d0");
        cfg1 = 4'd15;
        rise_pulse(0);
        expect_ack(0, 15, 1, "d15");
        chk(srv1, 3, "d15 served");

        // second rise two edges after the first is dropped
        cfg1 = 4'd2;
        rise_pulse(0);
        @(negedge clk);
        chk(busy1, 1, "drop busy");
        rise_pulse(0);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            chk(bus1.ack, 32'(k == 2), "drop ack");
        end
        chk(dcnt1, 1, "drop drop_cnt");
        chk(derr1, 1, "drop drop_err");
        chk(srv1, 4, "drop served");
        chk(busy1, 0, "drop busy end");
        rise_pulse(0);
        expect_ack(0, 2, 1, "third");
        chk(srv1, 5, "third served");
        chk(dcnt1, 1, "third drop_cnt");

        // rise on the ACK->IDLE edge is dropped
        cfg1 = 4'd1;
        rise_pulse(0);
        @(negedge clk);
        chk(busy1, 1, "lastack busy");
        rise_pulse(0);
        @(negedge clk);
        chk(busy1, 0, "lastack busy after");
        chk(bus1.ack, 0, "lastack ack");
        chk(dcnt1, 2, "lastack drop_cnt");
        chk(srv1, 6, "lastack served");
        @(negedge clk);
        chk(busy1, 0, "lastack idle");

        // ACK_WIDTH = 3, delay changed during WAIT
        rise_pulse(1);
        cfg3 = 4'd5;
        expect_ack(1, 2, 3, "w3 d2");
        rise_pulse(1);
        expect_ack(1, 5, 3, "w3 d5");
        chk(srv3, 2, "w3 served");
        chk(dcnt3, 0, "w3 drop_cnt");

        // reset during WAIT aborts the request
        cfg1 = 4'd5;
        rise_pulse(0);
        @(negedge clk);
        chk(busy1, 1, "rstwait busy");
        rst_n = 1'b0;
        #1;
        chk(bus1.ack, 0, "rstwait ack");
        chk(busy1, 0, "rstwait busy0");
        chk(srv1, 0, "rstwait served");
        chk(dcnt1, 0, "rstwait drop_cnt");
        chk(derr1, 0, "rstwait drop_err");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk(bus1.ack, 0, "rstwait no ack");
            chk(busy1, 0, "rstwait idle");
        end

        // req held high through reset release counts as a rise
        rst_n    = 1'b0;
        bus1.req = 1'b1;
        cfg1     = 4'd2;
        @(negedge clk);
        rst_n = 1'b1;
        expect_ack(0, 2, 1, "held");
        bus1.req = 1'b0;
        chk(srv1, 1, "held served");

        // saturation: 300 requests spaced 6 cycles apart
        for (int i = 0; i < 300; i++) begin
            rise_pulse(0);
            expect_ack(0, 2, 1, "sat");
        end
        chk(srv1, 255, "sat served");
        chk(dcnt1, 0, "sat drop_cnt");
        chk(derr1, 0, "sat drop_err");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
